// File: rtl/wb_lbus_pkg.sv
// wb_lbus_pkg: shared FSM encoding and width helpers for the Wishbone
// to local-bus bridge.
package wb_lbus_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/wb_lbus_tmo.sv
// wb_lbus_tmo: wait-state counter; cleared before WAIT, counts WAIT cycles
// and flags expiry at TIMEOUT-1 (built only with WB_LBUS_TIMEOUT_EN).
module wb_lbus_tmo
    import wb_lbus_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int CW = clog2(TIMEOUT) + 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == CW'(TIMEOUT - 1));

    // Saturate at expiry so a stalled FSM cannot wrap the count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_lbus_bridge.sv
// wb_lbus_bridge: Wishbone-classic slave fanning out to NUM_CH local-bus
// targets. Define WB_LBUS_TIMEOUT_EN to bound WAIT by TIMEOUT cycles.
module wb_lbus_bridge
    import wb_lbus_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int ADDR_W  = 8,
    parameter int CH_LSB  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 cyc_i,
    input  logic                 stb_i,
    input  logic                 we_i,
    input  logic [31:0]          adr_i,
    input  logic [31:0]          dat_i,
    output logic [31:0]          dat_o,
    output logic                 ack_o,
    output logic                 err_o,
    output logic [NUM_CH-1:0]    lb_wr_o,
    output logic [NUM_CH-1:0]    lb_rd_o,
    output logic [ADDR_W-1:0]    lb_addr_o,
    output logic [31:0]          lb_data_o,
    input  logic [NUM_CH*32-1:0] lb_data_i,
    input  logic [NUM_CH-1:0]    lb_rdy_i
);

    localparam int CH_W = ch_width(NUM_CH);

    state_e              state_q, state_d;
    logic                err_q, err_d;
    logic                we_q;
    logic [CH_W-1:0]     ch_q;
    logic [CH_W-1:0]     ch_in;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdat_q;
    logic [31:0]         dat_q;
    logic [31:0]         rd_slice;
    logic [NUM_CH-1:0]   ch_oh;
    logic                ch_ok;
    logic                rdy_sel;
    logic                capture;
    logic                rd_done;
    logic                tmo_clr;
    logic                tmo_run;
    logic                tmo_exp;
    logic                unused_ok;

    assign ch_in = adr_i[CH_LSB +: CH_W];
    assign ch_ok = 32'(ch_in) < NUM_CH;

    always_comb begin
        ch_oh    = '0;
        rd_slice = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_q == CH_W'(k)) begin
                ch_oh[k] = 1'b1;
                rd_slice = lb_data_i[32*k +: 32];
            end
        end
    end

    // Only the selected channel's ready can complete the access.
    assign rdy_sel = |(lb_rdy_i & ch_oh);

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        capture = 1'b0;
        rd_done = 1'b0;
        tmo_clr = 1'b0;
        tmo_run = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cyc_i && stb_i) begin
                    capture = 1'b1;
                    err_d   = !ch_ok;
                    state_d = ch_ok ? S_REQ : S_RESP;
                end
            end
            S_REQ: begin
                tmo_clr = 1'b1;
                if (!cyc_i) begin
                    state_d = S_IDLE;
                end else if (rdy_sel) begin
                    rd_done = !we_q;
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                tmo_run = 1'b1;
                if (!cyc_i) begin
                    state_d = S_IDLE;
                end else if (rdy_sel) begin
                    rd_done = !we_q;
                    state_d = S_RESP;
                end else if (tmo_exp) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            ch_q    <= '0;
            addr_q  <= '0;
            wdat_q  <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (capture) begin
                we_q   <= we_i;
                ch_q   <= ch_in;
                addr_q <= adr_i[ADDR_W-1:0];
                wdat_q <= dat_i;
            end
            if (rd_done) begin
                dat_q <= rd_slice;
            end
        end
    end

`ifdef WB_LBUS_TIMEOUT_EN
    wb_lbus_tmo #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr     (tmo_clr),
        .run     (tmo_run),
        .expired (tmo_exp)
    );
`else
    assign tmo_exp = 1'b0;
`endif

    assign unused_ok = ^{adr_i, tmo_clr, tmo_run, 32'(TIMEOUT)};

    assign lb_wr_o   = (state_q == S_REQ && we_q)  ? ch_oh : '0;
    assign lb_rd_o   = (state_q == S_REQ && !we_q) ? ch_oh : '0;
    assign ack_o     = (state_q == S_RESP) && !err_q;
    assign err_o     = (state_q == S_RESP) && err_q;
    assign dat_o     = dat_q;
    assign lb_addr_o = addr_q;
    assign lb_data_o = wdat_q;

endmodule

// File: tb/tb_wb_lbus_bridge.sv
// tb_wb_lbus_bridge: transaction-timed reference model compared against the
// bridge every cycle, plus directed literal checks on key scenarios.
module tb_wb_lbus_bridge;

    localparam int NUM_CH  = 3;
    localparam int ADDR_W  = 8;
    localparam int CH_LSB  = 8;
    localparam int TIMEOUT = 16;
`ifdef WB_LBUS_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 cyc = 1'b0;
    logic                 stb = 1'b0;
    logic                 we = 1'b0;
    logic [31:0]          adr = '0;
    logic [31:0]          wdat = '0;
    logic [31:0]          dat_o;
    logic                 ack, err;
    logic [NUM_CH-1:0]    lb_wr, lb_rd;
    logic [NUM_CH-1:0]    lb_rdy = '0;
    logic [ADDR_W-1:0]    lb_addr;
    logic [31:0]          lb_wdata;
    logic [NUM_CH*32-1:0] lb_rdata = '0;

    always #5 clk = ~clk;

    wb_lbus_bridge #(
        .NUM_CH (NUM_CH), .ADDR_W (ADDR_W),
        .CH_LSB (CH_LSB), .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .cyc_i     (cyc),
        .stb_i     (stb),
        .we_i      (we),
        .adr_i     (adr),
        .dat_i     (wdat),
        .dat_o     (dat_o),
        .ack_o     (ack),
        .err_o     (err),
        .lb_wr_o   (lb_wr),
        .lb_rd_o   (lb_rd),
        .lb_addr_o (lb_addr),
        .lb_data_o (lb_wdata),
        .lb_data_i (lb_rdata),
        .lb_rdy_i  (lb_rdy)
    );

    int checks = 0;
    int failures = 0;
    int cyc_cnt = 0;
    bit cmp_en = 1'b0;

    // Model state and per-cycle expectations.
    logic [31:0]       m_dat = '0, m_ldat = '0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic              e_ack, e_err;
    logic [NUM_CH-1:0] e_wr, e_rd;
    logic [31:0]       e_dat, e_ldat;
    logic [ADDR_W-1:0] e_addr;

    int                mon_term_cyc, mon_strb_cyc;
    logic              mon_ack, mon_err;
    logic [31:0]       mon_dat, mon_ldat;
    logic [NUM_CH-1:0] mon_wr, mon_rd;
    logic [ADDR_W-1:0] mon_addr;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h",
                     nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ack", 32'(ack), 32'(e_ack));
            chk("err", 32'(err), 32'(e_err));
            chk("lb_wr", 32'(lb_wr), 32'(e_wr));
            chk("lb_rd", 32'(lb_rd), 32'(e_rd));
            chk("dat_o", dat_o, e_dat);
            chk("lb_addr", 32'(lb_addr), 32'(e_addr));
            chk("lb_data", lb_wdata, e_ldat);
            if (ack || err) begin
                mon_term_cyc = cyc_cnt;
                mon_ack = ack;
                mon_err = err;
                mon_dat = dat_o;
            end
            if (|{lb_wr, lb_rd}) begin
                mon_strb_cyc = cyc_cnt;
                mon_wr = lb_wr;
                mon_rd = lb_rd;
                mon_addr = lb_addr;
                mon_ldat = lb_wdata;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc_cnt++;
    endtask

    task automatic set_exp();
        e_ack = 1'b0; e_err = 1'b0; e_wr = '0; e_rd = '0;
        e_dat = m_dat; e_addr = m_addr; e_ldat = m_ldat;
    endtask

    task automatic noise();
        lb_rdy   = NUM_CH'($urandom);
        lb_rdata = {$urandom, $urandom, $urandom};
    endtask

    task automatic clear_mon();
        mon_term_cyc = -1; mon_strb_cyc = -1;
        mon_ack = 1'b0; mon_err = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            cyc = 1'b0; stb = 1'b0;
            noise(); set_exp(); step();
        end
    endtask

    task automatic access(input bit w, input logic [31:0] a,
                          input logic [31:0] wd, input int n,
                          input logic [31:0] rd, input int abort_at,
                          output int t0);
        int ch, tend;
        bit tmo;
        logic [NUM_CH-1:0] oh;
        ch = int'(a[CH_LSB +: 2]);
        t0 = cyc_cnt;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = wd;
        noise(); set_exp(); step();
        m_addr = a[ADDR_W-1:0];
        m_ldat = wd;
        if (ch >= NUM_CH) begin
            noise(); set_exp(); e_err = 1'b1; step();
            return;
        end
        oh = NUM_CH'(1) << ch;
        tmo = TMO_EN && (n > TIMEOUT);
        tend = tmo ? 2 + TIMEOUT : 2 + n;
        for (int c = 1; c < tend; c++) begin
            noise();
            if (c == 3 && ch != 0) lb_rdy[0] = 1'b1;
            lb_rdy[ch] = (c == 1 + n);
            if (c == 1 + n) lb_rdata[32*ch +: 32] = rd;
            set_exp();
            if (c == 1) begin
                if (w) e_wr = oh;
                else e_rd = oh;
            end
            if (c == abort_at) begin
                cyc = 1'b0; stb = 1'b0; lb_rdy[ch] = 1'b0;
                step();
                for (int j = 0; j < 3; j++) begin
                    noise(); lb_rdy[ch] = 1'b1; set_exp(); step();
                end
                return;
            end
            step();
        end
        if (!tmo && !w) m_dat = rd;
        noise(); set_exp();
        if (tmo) e_err = 1'b1;
        else e_ack = 1'b1;
        step();
    endtask

    task automatic hang_then_reset(input int w);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0000_0033;
        wdat = $urandom;
        noise(); set_exp(); step();
        m_addr = 8'h33; m_ldat = wdat;
        noise(); lb_rdy[0] = 1'b0; set_exp(); e_rd = 3'b001; step();
        for (int c = 0; c < w; c++) begin
            noise(); lb_rdy[0] = 1'b0; set_exp(); step();
        end
        noise(); lb_rdy[0] = 1'b0;
        #1;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
        m_dat = '0; m_addr = '0; m_ldat = '0;
        set_exp();
        #1;
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_wr", 32'(lb_wr), 32'h0);
        chk("rst_rd", 32'(lb_rd), 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        chk("rst_addr", 32'(lb_addr), 32'h0);
        chk("rst_ldata", lb_wdata, 32'h0);
        step();
        noise(); set_exp(); step();
        rst_n = 1'b1;
    endtask

    initial begin
        int t0, n, abort_at;
        logic [31:0] a;
        set_exp();
        clear_mon();
        repeat (3) step();
        rst_n = 1'b1;
        chk("por_ack", 32'(ack), 32'h0);
        chk("por_dat", dat_o, 32'h0);
        chk("por_addr", 32'(lb_addr), 32'h0);
        cmp_en = 1'b1;
        idle(2);

        clear_mon();
        access(1'b1, 32'h0000_0104, 32'h1234_5678, 0, '0, -1, t0);
        chk("wr_strobe", 32'(mon_wr), 32'h2);
        chk("wr_strobe_cyc", 32'(mon_strb_cyc - t0), 32'd1);
        chk("wr_addr", 32'(mon_addr), 32'h04);
        chk("wr_data", mon_ldat, 32'h1234_5678);
        chk("wr_ack_lat", 32'(mon_term_cyc - t0), 32'd2);
        chk("wr_ack", 32'(mon_ack), 32'h1);
        idle(1);

        clear_mon();
        access(1'b0, 32'h0000_0210, '0, 5, 32'hCAFE_F00D, -1, t0);
        chk("rd_strobe", 32'(mon_rd), 32'h4);
        chk("rd_dat", mon_dat, 32'hCAFE_F00D);
        chk("rd_ack_lat", 32'(mon_term_cyc - t0), 32'd7);
        idle(1);

        clear_mon();
        access(1'b1, 32'h0000_0300, 32'h0BAD_0BAD, 0, '0, -1, t0);
        chk("dec_err", 32'(mon_err), 32'h1);
        chk("dec_lat", 32'(mon_term_cyc - t0), 32'd1);
        chk("dec_nostrobe", 32'(mon_strb_cyc), 32'hFFFF_FFFF);
        chk("dec_dat", dat_o, 32'hCAFE_F00D);
        idle(1);

        if (TMO_EN) begin
            clear_mon();
            access(1'b0, 32'h0000_0020, '0, 100, '0, -1, t0);
            chk("tmo_err", 32'(mon_err), 32'h1);
            chk("tmo_lat", 32'(mon_term_cyc - t0), 32'd18);
            idle(1);
            clear_mon();
            access(1'b0, 32'h0000_0024, '0, TIMEOUT, 32'h0F0F_1616, -1, t0);
            chk("tmo_tie_ack", 32'(mon_ack), 32'h1);
            chk("tmo_tie_lat", 32'(mon_term_cyc - t0), 32'd18);
            idle(1);
        end

        clear_mon();
        access(1'b0, 32'h0000_0010, '0, 6, 32'hDEAD_BEEF, 3, t0);
        chk("abort_noterm", 32'(mon_term_cyc), 32'hFFFF_FFFF);
        clear_mon();
        access(1'b0, 32'h0000_0120, '0, 2, 32'h5A5A_0001, -1, t0);
        chk("post_abort_dat", mon_dat, 32'h5A5A_0001);
        chk("post_abort_lat", 32'(mon_term_cyc - t0), 32'd4);
        idle(1);

        clear_mon();
        hang_then_reset(TMO_EN ? 10 : 1000);
        chk("hang_noterm", 32'(mon_term_cyc), 32'hFFFF_FFFF);
        idle(1);
        clear_mon();
        access(1'b1, 32'h0000_0008, 32'h0000_00A5, 1, '0, -1, t0);
        chk("after_rst_wr", 32'(mon_wr), 32'h1);
        chk("after_rst_lat", 32'(mon_term_cyc - t0), 32'd3);
        chk("after_rst_dat", dat_o, 32'h0);
        idle(1);

        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            a[CH_LSB +: 2] = 2'($urandom_range(0, 3));
            n = $urandom_range(0, 20);
            abort_at = -1;
            if (n >= 2 && $urandom_range(0, 4) == 0) begin
                abort_at = $urandom_range(1, n);
            end
            access(1'($urandom), a, $urandom, n, $urandom, abort_at, t0);
            idle($urandom_range(0, 2));
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_lbus_bridge.md
# wb_lbus_bridge

Parametrised Wishbone-classic slave to multi-channel local-bus bridge, the successor of the single-target Wishbone wrapper in front of the 1588 register file. It decodes one Wishbone access into one strobe on one of `NUM_CH` local-bus targets (RTC, RX TSU, TX TSU, …). It waits on a per-channel ready handshake and returns `ack_o`, or returns `err_o` on a decode error or timeout.

## Interface
- `NUM_CH`, default 3: number of local-bus targets, 1..8.
- `ADDR_W`, default 8: local-bus byte-address width.
- `CH_LSB`, default 8: `adr_i` bit where the channel-select field starts. The field is `CH_W = max(1, clog2(NUM_CH))` bits wide.
- `TIMEOUT`, default 16: cycles waited for `lb_rdy_i` before an error response (timeout feature only).
- `clk_i` in 1: single clock; all logic is rising-edge.
- `rst_n_i` in 1: asynchronous reset, active-low.
- `cyc_i`, `stb_i`, `we_i` in 1 each: Wishbone cycle, strobe and write enable.
- `adr_i` in 32: byte address.
- `dat_i` in 32: write data.
- `dat_o` out 32: read data, registered.
- `ack_o` out 1: normal termination, one-cycle pulse.
- `err_o` out 1: error termination, one-cycle pulse.
- `lb_wr_o` out `NUM_CH`: per-channel write strobe, one-hot, one-cycle pulse.
- `lb_rd_o` out `NUM_CH`: per-channel read strobe, one-hot, one-cycle pulse.
- `lb_addr_o` out `ADDR_W`: registered `adr_i[ADDR_W-1:0]`.
- `lb_data_o` out 32: registered `dat_i`.
- `lb_data_i` in `NUM_CH*32`: read data; channel k occupies bits `[32k+31:32k]`.
- `lb_rdy_i` in `NUM_CH`: per-channel completion (write accepted / read data valid).

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: when `cyc_i & stb_i` is sampled, register the address, write data, `we_i` and channel index `ch = adr_i[CH_LSB +: CH_W]`.
  - If `ch < NUM_CH`, go to REQ.
  - Otherwise go to RESP with error set. No strobe is issued.
- REQ: assert `lb_wr_o[ch]` or `lb_rd_o[ch]` for exactly this cycle.
  - If `lb_rdy_i[ch]` is high in this cycle, go to RESP (zero-wait target).
  - Otherwise go to WAIT.
- WAIT: hold until `lb_rdy_i[ch]`, then go to RESP. `lb_rdy_i` of other channels is ignored.
- On the completing `lb_rdy_i[ch]` of a read, capture the `lb_data_i` slice for `ch` into `dat_o`.
- `dat_o` holds its value until the next read capture. Writes, errors and timeouts leave it unchanged.
- RESP: pulse `ack_o` (or `err_o` if error is set) for one cycle, then go to IDLE.
- `ack_o` and `err_o` are never high together.
- Abort: if `cyc_i` drops in REQ or WAIT, go to IDLE with no termination pulse. A late `lb_rdy_i` is then ignored.
- `lb_addr_o` and `lb_data_o` stay stable from REQ until the next IDLE capture.
- Reset, asserted at any time including mid-transaction:
  - state returns to IDLE;
  - `ack_o`, `err_o`, `lb_wr_o`, `lb_rd_o` = 0;
  - `dat_o`, `lb_addr_o`, `lb_data_o` = 0;
  - timeout counter = 0.

## Timing
- Cycle 0: `stb_i` sampled in IDLE. Cycle 1: REQ strobe.
- Ready in cycle 1+n (n ≥ 0) gives `ack_o` in cycle 2+n.
- Minimum access latency: 2 cycles.
- Back-to-back accesses: a new access is sampled no earlier than the cycle after the `ack_o`/`err_o` pulse. The `stb_i` present during the ack cycle is never re-issued.
- Decode error: `err_o` in cycle 1.

## Configuration
- Macro `WB_LBUS_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT-1` with no ready, go to RESP with error set.
  - The ready seen in that same cycle wins: the response is `ack_o`.
- Undefined: no counter is built. WAIT is unbounded, and `err_o` comes only from decode errors.

## Structure
- Package `wb_lbus_pkg`: the FSM state enum and a `clog2` constant function for `CH_W`.
- Sub-module `wb_lbus_tmo`: the timeout counter. It is instantiated only under `WB_LBUS_TIMEOUT_EN` and has ports `clk_i`, `rst_n_i`, `clr`, `run`, `expired`.

## Test plan
- Write to channel 1 (`adr_i=0x0000_0104`, `dat_i=0x1234_5678`), `lb_rdy_i[1]` high in REQ: `lb_wr_o=3'b010` for one cycle, `lb_addr_o=0x04`, `lb_data_o=0x1234_5678`, `ack_o` 2 cycles after the sampled `stb_i`.
- Read from channel 2 with `lb_rdy_i[2]` asserted 5 cycles after the strobe and slice = `0xCAFE_F00D`: `dat_o=0xCAFE_F00D` in the `ack_o` cycle. `lb_rdy_i[0]` pulsed during WAIT has no effect.
- Access with channel field = 3 (`NUM_CH=3`): `err_o` pulse in cycle 1, no `lb_*` strobe, `dat_o` unchanged.
- With `WB_LBUS_TIMEOUT_EN` and `TIMEOUT=16`, target never ready: `err_o` exactly once, 18 cycles after the sampled `stb_i`. Without the macro, no termination after 1000 cycles.
- `cyc_i` dropped in WAIT, then `lb_rdy_i` pulsed: no `ack_o`/`err_o`, FSM in IDLE. A following read completes normally.
- `rst_n_i` asserted in WAIT: all outputs 0 immediately (asynchronous). After release, the first access behaves as from power-up.
